decode_issue_ctrl: RTL and testbench

- Parametrised successor to the combinational register-read decoder.
- Holds the F/D pipeline register and decodes register-file read addresses for the held instruction.
- Tracks in-flight destination registers in a shift-register scoreboard and stalls issue to execute on RAW hazards.
- Sits between fetch and the regfile/execute stage, with valid/ready handshakes on both sides.

---
 rtl/decode_issue_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_decode_issue_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue_ctrl
// Description : F/D pipeline register with register-read decode and a
//               shift-register scoreboard that stalls issue on RAW hazards.
//               Optional macro FORWARDING_EN restricts stalls to load-use.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_issue_ctrl #(
    parameter int PIPE_DEPTH = 3,
    parameter int LINK_REG   = 31,
    parameter int STATUS_REG = 30
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        fd_valid_in,
    input  logic [31:0] fd_insn_in,
    output logic        fd_ready_out,
    input  logic        flush,
    input  logic        dx_ready_in,
    output logic        dx_valid_out,
    output logic [31:0] dx_insn_out,
    output logic [4:0]  ctrl_readRegA,
    output logic [4:0]  ctrl_readRegB,
    output logic        hazard_stall
);

    localparam logic [4:0] c_OP_RTYPE = 5'b00000;
    localparam logic [4:0] c_OP_J     = 5'b00001;
    localparam logic [4:0] c_OP_BNE   = 5'b00010;
    localparam logic [4:0] c_OP_JAL   = 5'b00011;
    localparam logic [4:0] c_OP_JR    = 5'b00100;
    localparam logic [4:0] c_OP_ADDI  = 5'b00101;
    localparam logic [4:0] c_OP_BLT   = 5'b00110;
    localparam logic [4:0] c_OP_SW    = 5'b00111;
    localparam logic [4:0] c_OP_LW    = 5'b01000;
    localparam logic [4:0] c_OP_SETX  = 5'b10101;
    localparam logic [4:0] c_OP_BEX   = 5'b10110;

    localparam logic [4:0] c_LINK   = LINK_REG[4:0];
    localparam logic [4:0] c_STATUS = STATUS_REG[4:0];

    // D register
    logic        r_d_valid;
    logic [31:0] r_d_insn;

    // Scoreboard: entry 0 is the instruction just issued to X
    logic [PIPE_DEPTH-1:0] r_sb_valid;
    logic [4:0]            r_sb_dest [PIPE_DEPTH];
`ifdef FORWARDING_EN
    logic [PIPE_DEPTH-1:0] r_sb_load;
`endif

    // Decode results
    logic [4:0] w_opcode;
    logic [4:0] w_rd;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_use_a;
    logic       w_use_b;
    logic [4:0] w_addr_a;
    logic [4:0] w_addr_b;
    logic       w_dest_vld;
    logic [4:0] w_dest;
    logic [4:0] w_rd_a;
    logic [4:0] w_rd_b;

    logic       w_hazard;
    logic       w_issue;
    logic       w_fd_ready;
    logic       w_accept;

    assign w_opcode = r_d_insn[31:27];
    assign w_rd     = r_d_insn[26:22];
    assign w_rs     = r_d_insn[21:17];
    assign w_rt     = r_d_insn[16:12];

    // Operand and destination decode of the held instruction
    always_comb begin
        w_use_a    = 1'b0;
        w_use_b    = 1'b0;
        w_addr_a   = 5'd0;
        w_addr_b   = 5'd0;
        w_dest_vld = 1'b0;
        w_dest     = 5'd0;
        case (w_opcode)
            c_OP_RTYPE: begin
                w_use_a    = 1'b1;
                w_addr_a   = w_rs;
                w_use_b    = 1'b1;
                w_addr_b   = w_rt;
                w_dest_vld = 1'b1;
                w_dest     = w_rd;
            end
            c_OP_ADDI, c_OP_LW: begin
                w_use_a    = 1'b1;
                w_addr_a   = w_rs;
                w_dest_vld = 1'b1;
                w_dest     = w_rd;
            end
            c_OP_SW: begin
                w_use_a  = 1'b1;
                w_addr_a = w_rs;
                w_use_b  = 1'b1;
                w_addr_b = w_rd;
            end
            c_OP_BNE, c_OP_BLT: begin
                w_use_a  = 1'b1;
                w_addr_a = w_rd;
                w_use_b  = 1'b1;
                w_addr_b = w_rs;
            end
            c_OP_JR: begin
                w_use_a  = 1'b1;
                w_addr_a = w_rd;
            end
            c_OP_BEX: begin
                w_use_a  = 1'b1;
                w_addr_a = c_STATUS;
            end
            c_OP_J: begin
                w_use_a = 1'b0;
            end
            c_OP_JAL: begin
                w_dest_vld = 1'b1;
                w_dest     = c_LINK;
            end
            c_OP_SETX: begin
                w_dest_vld = 1'b1;
                w_dest     = c_STATUS;
            end
            default: begin
                w_dest_vld = 1'b0;
            end
        endcase
    end

    // Unused ports and an empty D register present address 0; since r0 never
    // hazards, a nonzero address also implies the port is in use.
    assign w_rd_a = (r_d_valid && w_use_a) ? w_addr_a : 5'd0;
    assign w_rd_b = (r_d_valid && w_use_b) ? w_addr_b : 5'd0;

    function automatic logic f_src_match(input logic [4:0] i_a,
                                         input logic [4:0] i_b,
                                         input logic [4:0] i_dest);
        return ((i_a != 5'd0) && (i_a == i_dest)) ||
               ((i_b != 5'd0) && (i_b == i_dest));
    endfunction

    // RAW hazard detection against the in-flight destinations
    always_comb begin
        w_hazard = 1'b0;
`ifdef FORWARDING_EN
        // Only a load sitting in X cannot be forwarded in time
        if (r_sb_valid[0] && r_sb_load[0]) begin
            w_hazard = f_src_match(w_rd_a, w_rd_b, r_sb_dest[0]);
        end
`else
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (r_sb_valid[i] && f_src_match(w_rd_a, w_rd_b, r_sb_dest[i])) begin
                w_hazard = 1'b1;
            end
        end
`endif
    end

    assign w_issue    = r_d_valid && !w_hazard && dx_ready_in && !flush;
    // Gated by reset_n so every output reads 0 while reset is held
    assign w_fd_ready = reset_n && (!r_d_valid || w_issue || flush);
    assign w_accept   = fd_valid_in && w_fd_ready;

    // D register: load on accept, otherwise drain on issue or flush
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_d_valid <= 1'b0;
            r_d_insn  <= 32'd0;
        end else if (w_accept) begin
            r_d_valid <= 1'b1;
            r_d_insn  <= fd_insn_in;
        end else if (w_issue || flush) begin
            r_d_valid <= 1'b0;
        end
    end

    // Scoreboard shifts toward W whenever execute advances, frozen otherwise
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sb_valid <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_sb_dest[i] <= 5'd0;
            end
`ifdef FORWARDING_EN
            r_sb_load <= '0;
`endif
        end else if (dx_ready_in) begin
            for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
                r_sb_valid[i] <= r_sb_valid[i-1];
                r_sb_dest[i]  <= r_sb_dest[i-1];
`ifdef FORWARDING_EN
                r_sb_load[i]  <= r_sb_load[i-1];
`endif
            end
            r_sb_valid[0] <= w_issue && w_dest_vld;
            r_sb_dest[0]  <= w_issue ? w_dest : 5'd0;
`ifdef FORWARDING_EN
            r_sb_load[0]  <= w_issue && (w_opcode == c_OP_LW);
`endif
        end
    end

    assign fd_ready_out  = w_fd_ready;
    assign dx_valid_out  = r_d_valid && !w_hazard && !flush;
    assign dx_insn_out   = r_d_insn;
    assign ctrl_readRegA = w_rd_a;
    assign ctrl_readRegB = w_rd_b;
    assign hazard_stall  = r_d_valid && w_hazard;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_issue_ctrl
// Description : Scoreboard bench for decode_issue_ctrl. Stimulus pushes the
//               expected issue stream; a monitor pops it on every issue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_issue_ctrl;

    localparam logic [4:0] c_RT   = 5'b00000;
    localparam logic [4:0] c_ADDI = 5'b00101;
    localparam logic [4:0] c_SW   = 5'b00111;
    localparam logic [4:0] c_LW   = 5'b01000;
    localparam logic [4:0] c_BEX  = 5'b10110;

`ifdef FORWARDING_EN
    localparam int c_EXP_ADDI = 0;
    localparam int c_EXP_LW   = 1;
`else
    localparam int c_EXP_ADDI = 3;
    localparam int c_EXP_LW   = 3;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        fd_valid_in = 1'b0;
    logic [31:0] fd_insn_in = 32'd0;
    logic        flush = 1'b0;
    logic        dx_ready_in = 1'b1;
    logic        fd_ready_out;
    logic        dx_valid_out;
    logic [31:0] dx_insn_out;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic        hazard_stall;

    decode_issue_ctrl #(
        .PIPE_DEPTH (3),
        .LINK_REG   (31),
        .STATUS_REG (30)
    ) u_dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .fd_valid_in   (fd_valid_in),
        .fd_insn_in    (fd_insn_in),
        .fd_ready_out  (fd_ready_out),
        .flush         (flush),
        .dx_ready_in   (dx_ready_in),
        .dx_valid_out  (dx_valid_out),
        .dx_insn_out   (dx_insn_out),
        .ctrl_readRegA (ctrl_readRegA),
        .ctrl_readRegB (ctrl_readRegB),
        .hazard_stall  (hazard_stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] insn;
        logic [4:0]  a;
        logic [4:0]  b;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 12'h000};
    endfunction

    // Monitor: every issue must match the head of the expected stream
    always @(negedge clock) begin
        if (reset_n && dx_valid_out && dx_ready_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue actual=0x%0h expected=none", dx_insn_out);
            end else begin
                m_e = exp_q.pop_front();
                check("issue_insn", dx_insn_out, m_e.insn);
                check("issue_readA", {27'd0, ctrl_readRegA}, {27'd0, m_e.a});
                check("issue_readB", {27'd0, ctrl_readRegB}, {27'd0, m_e.b});
            end
        end
    end

    task automatic send(input logic [31:0] insn, input bit push,
                        input logic [4:0] a, input logic [4:0] b);
        exp_t e;
        bit   got;
        got = 1'b0;
        fd_valid_in = 1'b1;
        fd_insn_in  = insn;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (fd_ready_out) begin
                got = 1'b1;
                break;
            end
        end
        check("accept", {31'd0, got}, 32'd1);
        if (push) begin
            e.insn = insn;
            e.a    = a;
            e.b    = b;
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1;
        fd_valid_in = 1'b0;
    endtask

    task automatic count_stalls(input string name, input int exp);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (hazard_stall) cnt++;
            else break;
        end
        check(name, cnt, exp);
        check({name, "_issue"}, {31'd0, dx_valid_out}, 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #3;
        check("rst_fd_ready", {31'd0, fd_ready_out}, 32'd0);
        check("rst_dx_valid", {31'd0, dx_valid_out}, 32'd0);
        check("rst_insn", dx_insn_out, 32'd0);
        check("rst_readA", {27'd0, ctrl_readRegA}, 32'd0);
        check("rst_hazard", {31'd0, hazard_stall}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_fd_ready", {31'd0, fd_ready_out}, 32'd1);
        check("post_rst_dx_valid", {31'd0, dx_valid_out}, 32'd0);

        // add r3,r1,r2: one-cycle latency
        send(mk(c_RT, 5'd3, 5'd1, 5'd2), 1'b1, 5'd1, 5'd2);
        @(negedge clock);
        check("lat_dx_valid", {31'd0, dx_valid_out}, 32'd1);
        check("lat_fd_ready", {31'd0, fd_ready_out}, 32'd1);
        @(posedge clock);
        #1;
        idle(1);

        // sw r4,0(r5) then bex
        send(mk(c_SW, 5'd4, 5'd5, 5'd0), 1'b1, 5'd5, 5'd4);
        send(mk(c_BEX, 5'd0, 5'd0, 5'd0), 1'b1, 5'd30, 5'd0);
        idle(3);

        // addi r7,r0,5 then add r8,r7,r7
        send(mk(c_ADDI, 5'd7, 5'd0, 5'd0) | 32'd5, 1'b1, 5'd0, 5'd0);
        send(mk(c_RT, 5'd8, 5'd7, 5'd7), 1'b1, 5'd7, 5'd7);
        count_stalls("raw_addi_stalls", c_EXP_ADDI);

        // r0 writer then r0 reader
        send(mk(c_ADDI, 5'd0, 5'd1, 5'd0) | 32'd1, 1'b1, 5'd1, 5'd0);
        send(mk(c_RT, 5'd11, 5'd0, 5'd0), 1'b1, 5'd0, 5'd0);
        count_stalls("r0_stalls", 0);

        // lw r9 then add r10,r9,r1
        send(mk(c_LW, 5'd9, 5'd1, 5'd0), 1'b1, 5'd1, 5'd0);
        send(mk(c_RT, 5'd10, 5'd9, 5'd1), 1'b1, 5'd9, 5'd1);
        count_stalls("raw_lw_stalls", c_EXP_LW);

        // Freeze with dx_ready_in low during a stall
        send(mk(c_LW, 5'd12, 5'd1, 5'd0), 1'b1, 5'd1, 5'd0);
        send(mk(c_RT, 5'd13, 5'd12, 5'd0), 1'b1, 5'd12, 5'd0);
        dx_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("freeze_stall", {31'd0, hazard_stall}, 32'd1);
            check("freeze_dx_valid", {31'd0, dx_valid_out}, 32'd0);
            check("freeze_insn", dx_insn_out, mk(c_RT, 5'd13, 5'd12, 5'd0));
        end
        @(posedge clock);
        #1;
        dx_ready_in = 1'b1;
        count_stalls("freeze_resume_stalls", c_EXP_LW);

        // Flush a stalled instruction while fetch delivers a new one
        send(mk(c_LW, 5'd14, 5'd1, 5'd0), 1'b1, 5'd1, 5'd0);
        send(mk(c_RT, 5'd15, 5'd14, 5'd14), 1'b0, 5'd0, 5'd0);
        flush       = 1'b1;
        fd_valid_in = 1'b1;
        fd_insn_in  = mk(c_RT, 5'd16, 5'd1, 5'd2);
        m_e.insn = fd_insn_in;
        m_e.a    = 5'd1;
        m_e.b    = 5'd2;
        exp_q.push_back(m_e);
        @(negedge clock);
        check("flush_fd_ready", {31'd0, fd_ready_out}, 32'd1);
        check("flush_dx_valid", {31'd0, dx_valid_out}, 32'd0);
        @(posedge clock);
        #1;
        flush       = 1'b0;
        fd_valid_in = 1'b0;
        @(negedge clock);
        check("flush_loaded", dx_insn_out, mk(c_RT, 5'd16, 5'd1, 5'd2));
        check("flush_new_valid", {31'd0, dx_valid_out}, 32'd1);
        @(posedge clock);
        #1;
        idle(2);

        // Asynchronous reset in the middle of a stall
        send(mk(c_LW, 5'd17, 5'd1, 5'd0), 1'b1, 5'd1, 5'd0);
        send(mk(c_RT, 5'd18, 5'd17, 5'd17), 1'b0, 5'd0, 5'd0);
        @(negedge clock);
        check("pre_rst_stall", {31'd0, hazard_stall}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_fd_ready", {31'd0, fd_ready_out}, 32'd0);
        check("mid_rst_dx_valid", {31'd0, dx_valid_out}, 32'd0);
        check("mid_rst_insn", dx_insn_out, 32'd0);
        check("mid_rst_readA", {27'd0, ctrl_readRegA}, 32'd0);
        check("mid_rst_readB", {27'd0, ctrl_readRegB}, 32'd0);
        check("mid_rst_hazard", {31'd0, hazard_stall}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("rel_rst_fd_ready", {31'd0, fd_ready_out}, 32'd1);
        check("rel_rst_dx_valid", {31'd0, dx_valid_out}, 32'd0);
        send(mk(c_RT, 5'd19, 5'd17, 5'd17), 1'b1, 5'd17, 5'd17);
        count_stalls("post_rst_stalls", 0);

        idle(5);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
